savestate_seq: RTL and testbench

//  Sequences save-state transfers between the system backup RAM and the mounted save image on SD.
//  - On a load or save request, walks 2**SECT_W consecutive 512-byte sectors of the selected slot

---
 rtl/savestate_seq.sv | 128 ++++++++++++
 tb/tb_savestate_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/savestate_seq.sv
// Save-state sequencer: moves one slot of 2**SECT_W sectors between backup RAM and the
// mounted SD save image through the hps_io sd_rd/sd_wr/sd_ack handshake.
module savestate_seq #(
   parameter int SECT_W    = 6,
   parameter int SLOT_W    = 2,
   parameter int TIMEOUT_W = 24
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              enable,
   input  logic              load_req,
   input  logic              save_req,
   input  logic [SLOT_W-1:0] slot,
   output logic [31:0]       sd_lba,
   output logic              sd_rd,
   output logic              sd_wr,
   input  logic              sd_ack,
   output logic              busy,
   output logic              loading,
   output logic              done,
   output logic              error
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;

   localparam logic [SECT_W-1:0]    SECT_LAST = '1;
   localparam logic [TIMEOUT_W-1:0] TO_LAST   = '1;

   // Handshake: sd_rd/sd_wr stay high until sd_ack rises; sd_lba holds from request
   // until sd_ack falls, and only then does the sequencer advance or finish.
   logic [1:0]           state;
   logic                 old_load, old_save, old_ack;
   logic                 op;
   logic                 abort;
   logic [TIMEOUT_W-1:0] ack_cnt;
   logic [TIMEOUT_W-1:0] cnt_inc;
   logic                 start_load, start_save;
   logic                 ack_rise, ack_fall;
   logic [31:0]          slot_base;

   assign start_load = load_req & ~old_load & enable;
   assign start_save = save_req & ~old_save & enable;
   assign ack_rise   = sd_ack & ~old_ack;
   assign ack_fall   = ~sd_ack & old_ack;
   assign cnt_inc    = ack_cnt + TIMEOUT_W'(1);
   assign slot_base  = 32'({slot, {SECT_W{1'b0}}});
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         old_load <= 1'b0;
         old_save <= 1'b0;
         old_ack  <= 1'b0;
         op       <= 1'b0;
         abort    <= 1'b0;
         ack_cnt  <= '0;
         sd_lba   <= '0;
         sd_rd    <= 1'b0;
         sd_wr    <= 1'b0;
         loading  <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         old_load <= load_req;
         old_save <= save_req;
         old_ack  <= sd_ack;
         done     <= 1'b0;
         case (state)
            S_IDLE: begin
               // Load wins a same-cycle tie with save.
               if (start_load | start_save) begin
                  op      <= start_load;
                  sd_lba  <= slot_base;
                  error   <= 1'b0;
                  loading <= start_load;
                  sd_rd   <= start_load;
                  sd_wr   <= ~start_load;
                  ack_cnt <= '0;
                  abort   <= 1'b0;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (ack_rise) begin
                  // Once HPS starts a sector it cannot be aborted; XFER handles a lost enable.
                  sd_rd   <= 1'b0;
                  sd_wr   <= 1'b0;
                  ack_cnt <= '0;
                  abort   <= ~enable;
                  state   <= S_XFER;
               end else if (~enable || cnt_inc == TO_LAST) begin
                  sd_rd   <= 1'b0;
                  sd_wr   <= 1'b0;
                  error   <= 1'b1;
                  loading <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  ack_cnt <= cnt_inc;
               end
            end
            S_XFER: begin
               if (~enable) abort <= 1'b1;
               if (ack_fall) begin
                  if (abort | ~enable) begin
                     error   <= 1'b1;
                     loading <= 1'b0;
                     state   <= S_IDLE;
                  end else if (sd_lba[SECT_W-1:0] == SECT_LAST) begin
                     loading <= 1'b0;
                     done    <= 1'b1;
                     state   <= S_IDLE;
                  end else begin
                     sd_lba[SECT_W-1:0] <= sd_lba[SECT_W-1:0] + SECT_W'(1);
                     sd_rd <= op;
                     sd_wr <= ~op;
                     state <= S_REQ;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_savestate_seq.sv
// Bench for savestate_seq: HPS ack model, request scoreboard and directed load/save scenarios.
module tb_savestate_seq;

   localparam int SECT_W    = 6;
   localparam int SLOT_W    = 2;
   localparam int TIMEOUT_W = 8;
   localparam int NSECT     = 64;

   logic              clk_sys = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic              load_req = 1'b0;
   logic              save_req = 1'b0;
   logic [SLOT_W-1:0] slot = '0;
   logic [31:0]       sd_lba;
   logic              sd_rd, sd_wr;
   logic              sd_ack;
   logic              busy, loading, done, error;

   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic        ack_en = 1'b1;
   logic        prev_req = 1'b0;
   logic [31:0] hps_lba;
   logic [33:0] exp_q[$];   // {sd_rd, sd_wr, sd_lba} expected at each request rise

   savestate_seq #(.SECT_W(SECT_W), .SLOT_W(SLOT_W), .TIMEOUT_W(TIMEOUT_W)) dut (
      .clk_sys(clk_sys), .reset(reset), .enable(enable), .load_req(load_req),
      .save_req(save_req), .slot(slot), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_ack(sd_ack), .busy(busy), .loading(loading), .done(done), .error(error)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_xfer(input logic is_load, input logic [SLOT_W-1:0] s);
      for (int i = 0; i < NSECT; i++)
         exp_q.push_back({is_load, ~is_load, (32'(s) << SECT_W) + 32'(i)});
   endtask

   task automatic wait_done(input string name, input int start);
      int i = 0;
      while (done_cnt == start && i < 3000) begin
         @(posedge clk_sys);
         i++;
      end
      repeat (10) @(negedge clk_sys);
      check({name, "_done_count"}, 34'(done_cnt - start), 34'd1);
      check({name, "_queue_left"}, 34'(exp_q.size()), 34'd0);
      check({name, "_error"}, 34'(error), 34'd0);
      check({name, "_busy_after"}, 34'(busy), 34'd0);
   endtask

   // HPS model: acks each request after two cycles and holds ack for three.
   initial begin
      sd_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (ack_en && !reset && (sd_rd || sd_wr) && !sd_ack) begin
            repeat (2) @(negedge clk_sys);
            hps_lba = sd_lba;
            sd_ack = 1'b1;
            repeat (3) begin
               @(negedge clk_sys);
               if (!reset) check("lba_stable", 34'(sd_lba), 34'(hps_lba));
            end
            sd_ack = 1'b0;
         end
      end
   end

   // Monitor: compares each new request against the scoreboard and checks done cycles.
   always @(negedge clk_sys) begin
      logic [33:0] e;
      if ((sd_rd || sd_wr) && !prev_req) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got rd=%0b wr=%0b lba=0x%0h expected none",
                     sd_rd, sd_wr, sd_lba);
         end else begin
            e = exp_q.pop_front();
            check("req", {sd_rd, sd_wr, sd_lba}, e);
            check("loading_at_req", 34'(loading), 34'(e[33]));
         end
      end
      prev_req = sd_rd | sd_wr;
      if (done) begin
         done_cnt++;
         check("busy_in_done", 34'(busy), 34'd0);
         check("loading_in_done", 34'(loading), 34'd0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int hi;
      int found;

      // Reset state
      #2 reset = 1'b1;
      #1;
      check("reset_ctrl", 34'({sd_rd, sd_wr, busy, loading, done, error}), 34'd0);
      check("reset_lba", 34'(sd_lba), 34'd0);
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;

      // 1) save of slot 2
      enable = 1'b1;
      slot = 2'd2;
      start = done_cnt;
      push_xfer(1'b0, 2'd2);
      @(negedge clk_sys) save_req = 1'b1;
      @(negedge clk_sys);
      check("t1_first", {sd_rd, sd_wr, sd_lba}, {2'b01, 32'h80});
      check("t1_busy_loading", 34'({busy, loading}), 34'b10);
      wait_done("t1", start);
      save_req = 1'b0;

      // 2) load of slot 0
      slot = 2'd0;
      start = done_cnt;
      push_xfer(1'b1, 2'd0);
      @(negedge clk_sys) load_req = 1'b1;
      @(negedge clk_sys);
      check("t2_first", {sd_rd, sd_wr, sd_lba}, {2'b10, 32'h00});
      check("t2_loading", 34'(loading), 34'd1);
      wait_done("t2", start);
      load_req = 1'b0;

      // 3) simultaneous edges: load wins; save edge while busy ignored
      slot = 2'd1;
      start = done_cnt;
      push_xfer(1'b1, 2'd1);
      @(negedge clk_sys);
      load_req = 1'b1;
      save_req = 1'b1;
      @(negedge clk_sys);
      check("t3_first", {sd_rd, sd_wr, sd_lba}, {2'b10, 32'h40});
      repeat (20) @(negedge clk_sys);
      save_req = 1'b0;
      @(negedge clk_sys) save_req = 1'b1;
      wait_done("t3", start);
      load_req = 1'b0;
      save_req = 1'b0;

      // 4) level already high when enable rises does not start
      @(negedge clk_sys) enable = 1'b0;
      repeat (2) @(negedge clk_sys);
      save_req = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("t4_busy_disabled", 34'(busy), 34'd0);
      enable = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("t4_no_start", 34'({busy, sd_wr, sd_rd}), 34'd0);
      save_req = 1'b0;
      @(negedge clk_sys);
      slot = 2'd3;
      start = done_cnt;
      push_xfer(1'b0, 2'd3);
      save_req = 1'b1;
      @(negedge clk_sys);
      check("t4_first", {sd_rd, sd_wr, sd_lba}, {2'b01, 32'hC0});
      wait_done("t4", start);
      save_req = 1'b0;

      // 5) no ack: timeout after 255 request cycles
      ack_en = 1'b0;
      slot = 2'd0;
      start = done_cnt;
      exp_q.push_back({2'b10, 32'h0});
      @(negedge clk_sys) load_req = 1'b1;
      @(negedge clk_sys);
      hi = 0;
      for (int i = 0; i < 400; i++) begin
         if (sd_rd) hi++;
         @(negedge clk_sys);
      end
      check("t5_rd_cycles", 34'(hi), 34'd255);
      check("t5_error_busy", 34'({error, busy}), 34'b10);
      check("t5_no_done", 34'(done_cnt - start), 34'd0);
      check("t5_queue", 34'(exp_q.size()), 34'd0);
      load_req = 1'b0;
      ack_en = 1'b1;
      @(negedge clk_sys);
      start = done_cnt;
      push_xfer(1'b1, 2'd0);
      load_req = 1'b1;
      @(negedge clk_sys);
      check("t5_error_cleared", 34'(error), 34'd0);
      wait_done("t5", start);
      load_req = 1'b0;

      // 6) async reset in XFER of sector 10
      slot = 2'd1;
      start = done_cnt;
      push_xfer(1'b0, 2'd1);
      @(negedge clk_sys) save_req = 1'b1;
      found = 0;
      for (int i = 0; i < 2000 && found == 0; i++) begin
         @(negedge clk_sys);
         if (sd_ack && !sd_wr && sd_lba == 32'h4A) found = 1;
      end
      check("t6_reached_sector10", 34'(found), 34'd1);
      #2 reset = 1'b1;
      #1;
      check("t6_reset_ctrl", 34'({sd_rd, sd_wr, busy, loading, done, error}), 34'd0);
      check("t6_reset_lba", 34'(sd_lba), 34'd0);
      save_req = 1'b0;
      repeat (4) @(negedge clk_sys);
      exp_q.delete();
      reset = 1'b0;
      @(negedge clk_sys);
      check("t6_no_done", 34'(done_cnt - start), 34'd0);
      push_xfer(1'b0, 2'd1);
      save_req = 1'b1;
      @(negedge clk_sys);
      check("t6_restart", {sd_rd, sd_wr, sd_lba}, {2'b01, 32'h40});
      wait_done("t6", start);
      save_req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
